// File: rtl/test_sequencer.sv
// Vector-driven test sequencer: reads operand/expected triples from a word memory,
// issues them to an ALU under test and scores each result as pass, fail or timeout.
//
// state  | meaning
// IDLE   | after reset, waiting for test_start
// RD_N   | read strobe for the vector count (word 0)
// CAP_N  | register and clamp the vector count
// RD_A   | read strobe for operand A of the current vector
// CAP_A  | register operand A
// RD_B   | read strobe for operand B
// CAP_B  | register operand B
// RD_E   | read strobe for the expected result
// CAP_E  | register the expected result
// ISSUE  | dut_valid held until dut_ready
// WAIT   | waiting for res_valid or the timeout
// DONE   | run complete, counts held, waiting for test_start
module test_sequencer #(
    parameter int DATA_W      = 32,
    parameter int MAX_VECTORS = 1024,
    parameter int WAIT_LIMIT  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              test_start,
    output logic              test_done,
    output logic [31:0]       pass_count,
    output logic [31:0]       fail_count,
    output logic              rd_en,
    output logic [31:0]       rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dut_valid,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    input  logic              dut_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] RD_N  = 4'd1;
    localparam logic [3:0] CAP_N = 4'd2;
    localparam logic [3:0] RD_A  = 4'd3;
    localparam logic [3:0] CAP_A = 4'd4;
    localparam logic [3:0] RD_B  = 4'd5;
    localparam logic [3:0] CAP_B = 4'd6;
    localparam logic [3:0] RD_E  = 4'd7;
    localparam logic [3:0] CAP_E = 4'd8;
    localparam logic [3:0] ISSUE = 4'd9;
    localparam logic [3:0] WAIT  = 4'd10;
    localparam logic [3:0] DONE  = 4'd11;

    localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    logic [3:0]        state_q, state_d;
    logic [31:0]       idx_q, idx_d;
    logic [31:0]       n_q, n_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       pass_q, pass_d;
    logic [31:0]       fail_q, fail_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [31:0]       addr_q, addr_d;
    logic              valid_q, valid_d;

    logic              score_pass;
    logic              score_fail;
    logic [31:0]       n_clamp;
    logic [31:0]       base_addr;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        exp_d      = exp_q;
        a_d        = a_q;
        b_d        = b_q;
        wait_d     = wait_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        score_pass = 1'b0;
        score_fail = 1'b0;

        // An over-range count read from memory is clamped rather than trusted
        if (rd_data > DATA_W'(MAX_VECTORS)) begin
            n_clamp = 32'(MAX_VECTORS);
        end else begin
            n_clamp = 32'(rd_data);
        end

        case (state_q)
            IDLE, DONE: begin
                if (test_start) begin
                    pass_d  = '0;
                    fail_d  = '0;
                    idx_d   = '0;
                    state_d = RD_N;
                end
            end
            RD_N:  state_d = CAP_N;
            CAP_N: begin
                n_d     = n_clamp;
                state_d = (n_clamp == 32'd0) ? DONE : RD_A;
            end
            RD_A:  state_d = CAP_A;
            CAP_A: begin
                a_d     = rd_data;
                state_d = RD_B;
            end
            RD_B:  state_d = CAP_B;
            CAP_B: begin
                b_d     = rd_data;
                state_d = RD_E;
            end
            RD_E:  state_d = CAP_E;
            CAP_E: begin
                exp_d   = rd_data;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (dut_ready) begin
                    wait_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle still gets compared
                if (res_valid) begin
                    if (res_data == exp_q) begin
                        score_pass = 1'b1;
                    end else begin
                        score_fail = 1'b1;
                    end
                end else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) begin
                    score_fail = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (score_pass && (pass_q != 32'hFFFF_FFFF)) begin
            pass_d = pass_q + 32'd1;
        end
        if (score_fail && (fail_q != 32'hFFFF_FFFF)) begin
            fail_d = fail_q + 32'd1;
        end
        if (score_pass || score_fail) begin
            if ((idx_q + 32'd1) < n_q) begin
                idx_d   = idx_q + 32'd1;
                state_d = RD_A;
            end else begin
                state_d = DONE;
            end
        end

        // Outputs are registered from the next state so they line up with it
        base_addr = 32'd1 + (idx_d * 32'd3);
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        case (state_d)
            RD_N: begin
                rd_en_d = 1'b1;
                addr_d  = 32'd0;
            end
            RD_A: begin
                rd_en_d = 1'b1;
                addr_d  = base_addr;
            end
            RD_B: begin
                rd_en_d = 1'b1;
                addr_d  = base_addr + 32'd1;
            end
            RD_E: begin
                rd_en_d = 1'b1;
                addr_d  = base_addr + 32'd2;
            end
            default: ;
        endcase
        valid_d = (state_d == ISSUE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            exp_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wait_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            exp_q   <= exp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wait_q  <= wait_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign test_done  = done_q;
    assign pass_count = pass_q;
    assign fail_count = fail_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = addr_q;
    assign dut_valid  = valid_q;
    assign dut_a      = a_q;
    assign dut_b      = b_q;

endmodule
